// File: rtl/opcode_fetch_unit_if.sv
// Byte-wide read port between the fetch unit and instruction memory.
// The fetch unit is the master: it holds mem_req/mem_addr until memory
// answers with mem_ack, and mem_rdata is valid in that same cycle.
interface opcode_fetch_unit_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/opcode_fetch_unit.sv
// Opcode/immediate fetch stage in front of the microcoded control unit.
// Holds the PC, reads opcode and operand bytes over a req/ack port, and
// pulses toggle_cb whenever the control unit must swap base/CB tables.
//
// state   | meaning
// IDLE    | no fetch in progress; pc_load, fetch_op and fetch_imm sampled here
// OP      | reading the opcode byte at PC
// CB_OP   | reading the byte that follows a CB prefix (never a prefix itself)
// IMM_LO  | reading the low operand byte
// IMM_HI  | reading the high operand byte (imm16 only)
module opcode_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [7:0]  CB_PREFIX = 8'hCB
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_op_i,
  input  logic [1:0]  fetch_imm_i,
  input  logic        pc_load_i,
  input  logic [15:0] pc_load_value_i,
  opcode_fetch_unit_if.master mem,
  output logic [7:0]  inst_buffer_o,
  output logic        inst_valid_o,
  output logic        toggle_cb_o,
  output logic [15:0] imm_data_o,
  output logic        imm_valid_o,
  output logic [15:0] pc_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OP     = 3'd1,
    S_CB_OP  = 3'd2,
    S_IMM_LO = 3'd3,
    S_IMM_HI = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        cb_active_q, cb_active_d;
  logic [7:0]  inst_buffer_q, inst_buffer_d;
  logic [15:0] imm_data_q, imm_data_d;
  logic        imm16_q, imm16_d;
  logic        inst_valid_q, inst_valid_d;
  logic        imm_valid_q, imm_valid_d;
  logic        toggle_cb_q, toggle_cb_d;

  logic idle;
  logic accept_op;
  logic accept_imm;
  logic ack;
  logic is_prefix;

  // Request decode; fetch_op outranks fetch_imm, which is then dropped
  always_comb begin
    idle       = (state_q == S_IDLE);
    accept_op  = idle && fetch_op_i;
    accept_imm = idle && !fetch_op_i && (fetch_imm_i != 2'd0);
    ack        = !idle && mem.mem_ack;
    is_prefix  = (mem.mem_rdata == CB_PREFIX);
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; every non-idle state waits indefinitely for ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_op) begin
          state_d = S_OP;
        end else if (accept_imm) begin
          state_d = S_IMM_LO;
        end
      end
      S_OP: begin
        if (ack) begin
          state_d = is_prefix ? S_CB_OP : S_IDLE;
        end
      end
      S_CB_OP: begin
        if (ack) begin
          state_d = S_IDLE;
        end
      end
      S_IMM_LO: begin
        if (ack) begin
          state_d = imm16_q ? S_IMM_HI : S_IDLE;
        end
      end
      S_IMM_HI: begin
        if (ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: the memory port is driven from state and PC only
  always_comb begin
    mem.mem_req   = (state_q != S_IDLE);
    mem.mem_addr  = pc_q;
    busy_o        = (state_q != S_IDLE);
    inst_buffer_o = inst_buffer_q;
    inst_valid_o  = inst_valid_q;
    toggle_cb_o   = toggle_cb_q;
    imm_data_o    = imm_data_q;
    imm_valid_o   = imm_valid_q;
    pc_o          = pc_q;
  end

  // Datapath next values: PC, buffers and the one-cycle pulses
  always_comb begin
    pc_d          = pc_q;
    cb_active_d   = cb_active_q;
    inst_buffer_d = inst_buffer_q;
    imm_data_d    = imm_data_q;
    imm16_d       = imm16_q;
    inst_valid_d  = 1'b0;
    imm_valid_d   = 1'b0;
    toggle_cb_d   = 1'b0;

    // A load in IDLE lands before the request, so the first read uses it
    if (idle && pc_load_i) begin
      pc_d = pc_load_value_i;
    end
    if (ack) begin
      pc_d = pc_q + 16'd1;
    end

    // Put the control unit back on the base table before the next opcode
    if (accept_op && cb_active_q) begin
      cb_active_d = 1'b0;
      toggle_cb_d = 1'b1;
    end

    if (accept_imm) begin
      imm16_d = fetch_imm_i[1];
    end

    if (ack) begin
      case (state_q)
        S_OP: begin
          if (is_prefix) begin
            cb_active_d = 1'b1;
            toggle_cb_d = 1'b1;
          end else begin
            inst_buffer_d = mem.mem_rdata;
            inst_valid_d  = 1'b1;
          end
        end
        S_CB_OP: begin
          inst_buffer_d = mem.mem_rdata;
          inst_valid_d  = 1'b1;
        end
        S_IMM_LO: begin
          imm_data_d[7:0] = mem.mem_rdata;
          if (!imm16_q) begin
            imm_data_d[15:8] = 8'h00;
            imm_valid_d      = 1'b1;
          end
        end
        S_IMM_HI: begin
          imm_data_d[15:8] = mem.mem_rdata;
          imm_valid_d      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; reset abandons any in-flight read and its ack
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      cb_active_q   <= 1'b0;
      inst_buffer_q <= 8'h00;
      imm_data_q    <= 16'h0000;
      imm16_q       <= 1'b0;
      inst_valid_q  <= 1'b0;
      imm_valid_q   <= 1'b0;
      toggle_cb_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      cb_active_q   <= cb_active_d;
      inst_buffer_q <= inst_buffer_d;
      imm_data_q    <= imm_data_d;
      imm16_q       <= imm16_d;
      inst_valid_q  <= inst_valid_d;
      imm_valid_q   <= imm_valid_d;
      toggle_cb_q   <= toggle_cb_d;
    end
  end

endmodule

// File: tb/tb_opcode_fetch_unit.sv
// Directed bench for opcode_fetch_unit. Each stimulus task plays one fetch
// transaction and, knowing which byte it returns on which edge, sets the
// expected per-cycle outputs; one process compares them on every falling edge.
module tb_opcode_fetch_unit;

  localparam logic [7:0] CB = 8'hCB;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_op;
  logic [1:0]  fetch_imm;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [7:0]  inst_buffer;
  logic        inst_valid;
  logic        toggle_cb;
  logic [15:0] imm_data;
  logic        imm_valid;
  logic [15:0] pc;
  logic        busy;

  opcode_fetch_unit_if mem_if ();

  opcode_fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .fetch_op_i      (fetch_op),
    .fetch_imm_i     (fetch_imm),
    .pc_load_i       (pc_load),
    .pc_load_value_i (pc_load_value),
    .mem             (mem_if),
    .inst_buffer_o   (inst_buffer),
    .inst_valid_o    (inst_valid),
    .toggle_cb_o     (toggle_cb),
    .imm_data_o      (imm_data),
    .imm_valid_o     (imm_valid),
    .pc_o            (pc),
    .busy_o          (busy)
  );

  always #5 clock = ~clock;

  logic [7:0] mem_m [int];

  // model of the architectural state and the expected pulses this cycle
  logic [15:0] m_pc;
  logic [15:0] m_imm;
  logic [7:0]  m_inst;
  bit          m_cb;
  bit          e_busy, e_iv, e_mv, e_tg;
  bit          chk_en = 1'b0;

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  int tg_seen = 0, iv_seen = 0, mv_seen = 0;
  int iv_cyc = 0, mv_cyc = 0, req_cyc = 0;
  int tg_base, mv_base;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] rd(input logic [15:0] a);
    return mem_m.exists(int'(a)) ? mem_m[int'(a)] : 8'h00;
  endfunction

  // per-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk1("busy", busy, e_busy);
      chk1("mem_req", mem_if.mem_req, e_busy);
      if (e_busy) chk("mem_addr", mem_if.mem_addr, m_pc);
      chk1("inst_valid", inst_valid, e_iv);
      chk1("imm_valid", imm_valid, e_mv);
      chk1("toggle_cb", toggle_cb, e_tg);
      chk("inst_buffer", {8'h00, inst_buffer}, {8'h00, m_inst});
      chk("imm_data", imm_data, m_imm);
      if (toggle_cb === 1'b1) tg_seen++;
      if (inst_valid === 1'b1) begin iv_seen++; iv_cyc = cyc; end
      if (imm_valid === 1'b1) begin mv_seen++; mv_cyc = cyc; end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    e_iv = 1'b0;
    e_mv = 1'b0;
    e_tg = 1'b0;
  endtask

  // memory side: wait states, then one acked byte from the model PC
  task automatic serve_byte(input int waits, input bit noise, output logic [7:0] data);
    for (int i = 0; i < waits; i++) begin
      if (noise) begin
        fetch_op = 1'b1; pc_load = 1'b1; pc_load_value = 16'hBEEF; fetch_imm = 2'd1;
      end
      tick();
    end
    fetch_op = 1'b0; pc_load = 1'b0; fetch_imm = 2'd0;
    data = rd(m_pc);
    mem_if.mem_ack = 1'b1;
    mem_if.mem_rdata = data;
    tick();
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = 8'h00;
    m_pc = m_pc + 16'd1;
  endtask

  task automatic start_op(input bit load, input logic [15:0] tgt, input logic [1:0] imm);
    fetch_op = 1'b1; pc_load = load; pc_load_value = tgt; fetch_imm = imm;
    req_cyc = cyc;
    tick();
    fetch_op = 1'b0; pc_load = 1'b0; fetch_imm = 2'd0;
    if (load) m_pc = tgt;
    e_busy = 1'b1;
    if (m_cb) begin e_tg = 1'b1; m_cb = 1'b0; end
  endtask

  task automatic finish_op(input int waits, input bit stop_at_prefix);
    logic [7:0] d;
    bit after_prefix = 1'b0;
    for (int k = 0; k < 2; k++) begin
      serve_byte(waits, 1'b0, d);
      if (!after_prefix && d == CB) begin
        e_tg = 1'b1; m_cb = 1'b1; after_prefix = 1'b1;
        if (stop_at_prefix) return;
      end else begin
        m_inst = d; e_iv = 1'b1; e_busy = 1'b0;
        return;
      end
    end
  endtask

  task automatic imm_fetch(input logic [1:0] n, input int waits, input bit noise_hi);
    logic [7:0] d;
    fetch_imm = n;
    req_cyc = cyc;
    tick();
    fetch_imm = 2'd0;
    e_busy = 1'b1;
    serve_byte(waits, 1'b0, d);
    m_imm[7:0] = d;
    if (n == 2'd1) begin
      m_imm[15:8] = 8'h00; e_mv = 1'b1; e_busy = 1'b0;
    end else begin
      serve_byte(waits, noise_hi, d);
      m_imm[15:8] = d; e_mv = 1'b1; e_busy = 1'b0;
    end
  endtask

  // reset with a coinciding ack: the ack must be discarded
  task automatic reset_now(input logic [7:0] data);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = data; reset = 1'b1;
    tick();
    reset = 1'b0; mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 8'h00;
    m_pc = 16'h0000; m_inst = 8'h00; m_imm = 16'h0000; m_cb = 1'b0; e_busy = 1'b0;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_inst", {8'h00, inst_buffer}, 16'h0000);
    chk1("rst_req", mem_if.mem_req, 1'b0);
    chk1("rst_iv", inst_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fetch_op = 1'b0; fetch_imm = 2'd0; pc_load = 1'b0; pc_load_value = 16'h0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 8'h00;
    mem_m[0] = 8'h3E; mem_m[1] = 8'h34; mem_m[2] = 8'h12; mem_m[3] = CB;
    mem_m[4] = 8'h7C; mem_m[5] = 8'h00; mem_m[6] = 8'hAA; mem_m[7] = 8'h55;
    mem_m[8] = 8'h47; mem_m[16'hFFFF] = 8'h06;
    m_pc = 16'h0000; m_imm = 16'h0000; m_inst = 8'h00; m_cb = 1'b0;
    e_busy = 1'b0; e_iv = 1'b0; e_mv = 1'b0; e_tg = 1'b0;

    tick();
    chk_en = 1'b1;
    chk("init_pc", pc, 16'h0000);
    chk1("init_busy", busy, 1'b0);
    tick(); tick();
    reset = 1'b0;

    // plain opcode, zero wait
    start_op(1'b0, 16'h0, 2'd0); finish_op(0, 1'b0); tick();
    chk("t1_inst", {8'h00, inst_buffer}, 16'h003E);
    chk("t1_pc", pc, 16'h0001);
    chk("t1_latency", 16'(iv_cyc - req_cyc), 16'd2);

    // imm16 with three wait states per byte
    mv_base = mv_seen;
    imm_fetch(2'd2, 3, 1'b0); tick();
    chk("t2_imm", imm_data, 16'h1234);
    chk("t2_pc", pc, 16'h0003);
    chk("t2_pulses", 16'(mv_seen - mv_base), 16'd1);

    // CB prefix, then the next fetch restores the base table
    tg_base = tg_seen;
    start_op(1'b0, 16'h0, 2'd0); finish_op(0, 1'b0); tick();
    chk("t3_inst", {8'h00, inst_buffer}, 16'h007C);
    chk("t3_toggles", 16'(tg_seen - tg_base), 16'd1);
    chk("t3_latency", 16'(iv_cyc - req_cyc), 16'd3);
    start_op(1'b0, 16'h0, 2'd0); finish_op(1, 1'b0); tick();
    chk("t3_inst2", {8'h00, inst_buffer}, 16'h0000);
    chk("t3_toggles2", 16'(tg_seen - tg_base), 16'd2);
    chk("t3_pc", pc, 16'h0006);

    // fetch_imm = 3 behaves as imm16
    imm_fetch(2'd3, 0, 1'b0); tick();
    chk("t3b_imm", imm_data, 16'h55AA);
    chk("t3b_latency", 16'(mv_cyc - req_cyc), 16'd3);
    chk("t3b_pc", pc, 16'h0008);

    // fetch_op and fetch_imm together: imm dropped
    mv_base = mv_seen;
    start_op(1'b0, 16'h0, 2'd2); finish_op(0, 1'b0); tick(); tick();
    chk("t3c_inst", {8'h00, inst_buffer}, 16'h0047);
    chk("t3c_pc", pc, 16'h0009);
    chk("t3c_no_imm", 16'(mv_seen - mv_base), 16'd0);

    // load 0xFFFF with fetch, then imm8 across the wrap
    start_op(1'b1, 16'hFFFF, 2'd0); finish_op(0, 1'b0); tick();
    chk("t4_inst", {8'h00, inst_buffer}, 16'h0006);
    chk("t4_pc_wrap", pc, 16'h0000);
    imm_fetch(2'd1, 1, 1'b0); tick();
    chk("t4_imm8", imm_data, 16'h003E);
    chk("t4_pc", pc, 16'h0001);

    // requests pulsed during IMM_HI waits are ignored
    imm_fetch(2'd2, 2, 1'b1); tick();
    chk("t5_imm", imm_data, 16'h1234);
    chk("t5_pc", pc, 16'h0003);

    // reset in CB_OP with ack, then reset in OP with ack
    tg_base = tg_seen;
    start_op(1'b1, 16'h0003, 2'd0); finish_op(0, 1'b1);
    reset_now(8'h7C);
    start_op(1'b0, 16'h0, 2'd0);
    reset_now(8'h3E);
    chk("t6_toggles", 16'(tg_seen - tg_base), 16'd1);
    start_op(1'b0, 16'h0, 2'd0); finish_op(0, 1'b0); tick();
    chk("t6_inst", {8'h00, inst_buffer}, 16'h003E);
    chk("t6_pc", pc, 16'h0001);
    chk("t6_no_toggle", 16'(tg_seen - tg_base), 16'd1);

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
